win_coef_loader: RTL and testbench
==================================

Name: win_coef_loader

Overview:
- APB initiator that programs the window-function block over its APB slave port.
- Takes window coefficients as an AXI-Stream packet and performs the full configuration sequence:
  - FSM soft reset
  - FFT_SIZE window-register writes
  - CHANGE STATE command
  - status check
- Sits between a coefficient source (DMA/ROM streamer) and the window block's APB port, replacing software-driven configuration.

Parameters:
- FFT_SIZE, 8192, number of window samples; power of 2, must match the target block.
- APB_AW, $clog2(FFT_SIZE-1)+3, APB address width; derived, do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to begin a load sequence
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a sequence ends, on success or error
- err  out  2  result code, valid with done and held until the next start: 0 ok, 1 length error, 2 status error, 3 readback error
- s_tvalid  in  1  coefficient stream valid
- s_tready  out  1  coefficient stream ready
- s_tdata  in  32  coefficient: [31:16] Im, [15:0] Re
- s_tlast  in  1  marks the last coefficient
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- paddr  out  APB_AW  APB byte address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data

Behaviour:
- Reset values (rst_n low at a clk edge): all outputs 0; err=0; word counter 0; state IDLE.
- Reset mid-sequence: psel/penable drop at that edge; the target is left partially programmed.
- APB protocol:
  - The target has no pready/pslverr, so every transfer is exactly 2 cycles: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1).
  - paddr, pwrite and pwdata are stable across both cycles. psel=0 between transfers.
  - Read data is sampled from prdata at the ACCESS cycle's closing edge.
- Address map used, with N=FFT_SIZE:
  - Window word k at k*4.
  - CTRL at N*4.
  - STATUS at (N+1)*4.
- States:
  - IDLE: start=1 moves to RST_WR. start is ignored in all other states.
  - RST_WR: write CTRL=0x0000_0001, then go to FETCH.
  - FETCH:
    - s_tready=1, the only state where it is high.
    - On s_tvalid&s_tready: capture s_tdata into pwdata, set paddr=cnt*4, go to COEF_WR.
    - tlast check:
      - s_tlast=1 with cnt<N-1: err=1, go to DONE with no window write for that word.
      - s_tlast=0 with cnt=N-1: err=1, go to DONE after that word's write.
  - COEF_WR:
    - Write the captured word.
    - After ACCESS: if cnt=N-1, go to GO_WR; else cnt+1 and back to FETCH.
  - GO_WR: write CTRL=0x0000_0100 (CHANGE STATE), then go to STAT_RD.
  - STAT_RD:
    - Read STATUS.
    - prdata[9:8]==2'b01 (WAIT) → err=0; else err=2.
    - Go to VFY_RD when the feature is on, else DONE.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- Latency, with s_tvalid held high: start seen at edge t0 → first SETUP in cycle t0+1.
  - Busy cycles = 2 (RST_WR) + 3N + 2 (GO_WR) + 2 (STAT_RD), then 1 DONE cycle.
  - Each coefficient costs 1 FETCH cycle + 2 APB cycles; s_tvalid gaps only extend FETCH.
- A length error never issues the CHANGE STATE write; the target stays in IDLE.

Optional Feature:
- Macro: WIN_LOADER_READBACK_EN.
- Defined:
  - After STAT_RD, write CTRL=0x1 to return the target to IDLE.
  - Then read back window words 0..N-1 (2 cycles each).
  - Each read word is compared with a running CRC-free XOR/position-compare against a shadow: the loader keeps a 32-bit XOR of all written words and compares it with the XOR of all read words.
  - Mismatch → err=3 (takes priority over err=0 only).
  - Finally rewrite CTRL=0x100, then DONE.
  - Adds 2+2N+2 cycles.
- Not defined: STAT_RD goes directly to DONE; err=3 is never produced.

Test Plan:
1. FFT_SIZE=8 (APB_AW=6), stream 0x0001_0000..0x0008_0007, s_tvalid always 1, tlast on 8th word, model status=0x100 → writes (0x20,0x1), (0x00..0x1C, words in order), (0x20,0x100), read 0x24; done pulse 31 cycles after start edge; err=0.
2. Same stream with s_tvalid low for 5 cycles before each word → identical APB write sequence, s_tready stays high during gaps, psel=0 during gaps, err=0.
3. s_tlast on 5th word (k=4) → 4 window writes only, no write of 0x100 to 0x20, done with err=1, busy=0 next cycle.
4. Status model returns 0x0000_0000 → full write sequence, done with err=2.
5. rst_n low during ACCESS of word 3 → psel=penable=busy=0 next cycle; a later start restarts with (0x20,0x1) and k=0.
6. start pulsed while busy → ignored, transfer count unchanged. With WIN_LOADER_READBACK_EN, model corrupts word 2 on readback → err=3.

Source files
------------

// File: rtl/win_coef_loader.sv
// APB initiator that loads window coefficients from an AXI-Stream packet into the window block.
// Optional readback verification of the loaded words is enabled by defining WIN_LOADER_READBACK_EN.
module win_coef_loader #(
  parameter int unsigned FFT_SIZE = 8192,
  parameter int unsigned APB_AW   = $clog2(FFT_SIZE - 1) + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);

  localparam int unsigned       CW        = $clog2(FFT_SIZE);
  localparam logic [CW-1:0]     LAST_IDX  = CW'(FFT_SIZE - 1);
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE * 4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE + 1) * 4);
  localparam logic [31:0]       CMD_RST   = 32'h0000_0001;
  localparam logic [31:0]       CMD_GO    = 32'h0000_0100;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WR, S_FETCH, S_COEF_WR, S_GO_WR, S_STAT_RD,
    S_RB_RST_WR, S_VFY_RD, S_RB_GO_WR, S_DONE
  } state_t;

  state_t            state, state_d;
  logic              phase, phase_d;      // 0 = SETUP, 1 = ACCESS
  logic [CW-1:0]     cnt, cnt_d;
  logic [1:0]        err_d;
  logic [31:0]       word, word_d;
  logic              len_err, len_err_d;  // last word arrived without tlast
  logic              psel_d, penable_d, pwrite_d, s_tready_d, busy_d, done_d;
  logic [APB_AW-1:0] paddr_d;
  logic [31:0]       pwdata_d;

`ifdef WIN_LOADER_READBACK_EN
  logic [31:0] xor_wr, xor_wr_d, xor_rd, xor_rd_d;
`else
  logic unused_prdata;
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};
`endif

  // State, sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= 1'b0;
      cnt      <= '0;
      err      <= 2'd0;
      word     <= '0;
      len_err  <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      s_tready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef WIN_LOADER_READBACK_EN
      xor_wr   <= '0;
      xor_rd   <= '0;
`endif
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      cnt      <= cnt_d;
      err      <= err_d;
      word     <= word_d;
      len_err  <= len_err_d;
      psel     <= psel_d;
      penable  <= penable_d;
      pwrite   <= pwrite_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      s_tready <= s_tready_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef WIN_LOADER_READBACK_EN
      xor_wr   <= xor_wr_d;
      xor_rd   <= xor_rd_d;
`endif
    end
  end

  // Next state; every APB state spends one SETUP and one ACCESS cycle
  always_comb begin
    state_d   = state;
    phase_d   = phase;
    cnt_d     = cnt;
    err_d     = err;
    word_d    = word;
    len_err_d = len_err;
`ifdef WIN_LOADER_READBACK_EN
    xor_wr_d  = xor_wr;
    xor_rd_d  = xor_rd;
`endif
    if (state != S_IDLE && state != S_FETCH && state != S_DONE && !phase)
      phase_d = 1'b1;
    else begin
      phase_d = 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RST_WR;
            cnt_d     = '0;
            err_d     = 2'd0;
            len_err_d = 1'b0;
`ifdef WIN_LOADER_READBACK_EN
            xor_wr_d  = '0;
            xor_rd_d  = '0;
`endif
          end
        end
        S_RST_WR: state_d = S_FETCH;
        S_FETCH: begin
          if (s_tvalid && s_tready) begin
            if (s_tlast && cnt != LAST_IDX) begin
              err_d   = 2'd1;
              state_d = S_DONE;
            end else begin
              word_d    = s_tdata;
              len_err_d = !s_tlast && cnt == LAST_IDX;
              state_d   = S_COEF_WR;
`ifdef WIN_LOADER_READBACK_EN
              xor_wr_d  = xor_wr ^ s_tdata;
`endif
            end
          end
        end
        S_COEF_WR: begin
          if (cnt == LAST_IDX) begin
            if (len_err) begin
              err_d   = 2'd1;
              state_d = S_DONE;
            end else
              state_d = S_GO_WR;
          end else begin
            cnt_d   = cnt + CW'(1);
            state_d = S_FETCH;
          end
        end
        S_GO_WR: state_d = S_STAT_RD;
        S_STAT_RD: begin
          err_d = (prdata[9:8] == 2'b01) ? 2'd0 : 2'd2;
`ifdef WIN_LOADER_READBACK_EN
          state_d = S_RB_RST_WR;
`else
          state_d = S_DONE;
`endif
        end
`ifdef WIN_LOADER_READBACK_EN
        S_RB_RST_WR: begin
          cnt_d   = '0;
          state_d = S_VFY_RD;
        end
        S_VFY_RD: begin
          xor_rd_d = xor_rd ^ prdata;
          if (cnt == LAST_IDX) begin
            if ((xor_rd ^ prdata) != xor_wr && err == 2'd0) err_d = 2'd3;
            state_d = S_RB_GO_WR;
          end else
            cnt_d = cnt + CW'(1);
        end
        S_RB_GO_WR: state_d = S_DONE;
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output values for the state being entered
  always_comb begin
    psel_d     = 1'b0;
    pwrite_d   = 1'b0;
    paddr_d    = paddr;
    pwdata_d   = pwdata;
    s_tready_d = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_RST_WR, S_RB_RST_WR: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = CTRL_ADDR;
        pwdata_d = CMD_RST;
      end
      S_COEF_WR: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = APB_AW'({cnt_d, 2'b00});
        pwdata_d = word_d;
      end
      S_GO_WR, S_RB_GO_WR: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = CTRL_ADDR;
        pwdata_d = CMD_GO;
      end
      S_STAT_RD: begin
        psel_d  = 1'b1;
        paddr_d = STAT_ADDR;
      end
      S_VFY_RD: begin
        psel_d  = 1'b1;
        paddr_d = APB_AW'({cnt_d, 2'b00});
      end
      default: ;
    endcase
    penable_d = psel_d && phase_d;
  end

endmodule

// File: tb/tb_win_coef_loader.sv
// Directed bench for win_coef_loader with FFT_SIZE=8: APB target model, transfer log and hand-computed expectations.
module tb_win_coef_loader;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 6;
`ifdef WIN_LOADER_READBACK_EN
  localparam int RBX = 20;
`else
  localparam int RBX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, s_tvalid, s_tready, s_tlast;
  logic          busy, done, psel, penable, pwrite;
  logic [1:0]    err;
  logic [31:0]   s_tdata, pwdata, prdata;
  logic [AW-1:0] paddr;

  always #5 clk = ~clk;

  win_coef_loader #(.FFT_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // APB target model
  logic [31:0] mem [16];
  logic [31:0] status_val;
  logic        corrupt;
  logic [3:0]  idx;

  always_comb begin
    idx = paddr[5:2];
    if (idx == 4'd9) prdata = status_val;
    else             prdata = mem[idx] ^ ((corrupt && idx == 4'd2) ? 32'h0000_00FF : 32'h0);
  end

  // Transfer log and protocol monitor
  logic [38:0]   log_q[$];
  logic [38:0]   exp_q[$];
  logic          prev_setup = 1'b0;
  logic          prev_write = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [31:0]   prev_wdata = '0;
  int            viol = 0, overlap = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (psel && penable) begin
      log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
      if (pwrite) mem[paddr[5:2]] <= pwdata;
    end
    if (prev_setup && !(psel && penable && paddr == prev_addr && pwdata == prev_wdata && pwrite == prev_write))
      viol <= viol + 1;
    else if (penable && !prev_setup)
      viol <= viol + 1;
    prev_setup <= psel && !penable;
    prev_addr  <= paddr;
    prev_wdata <= pwdata;
    prev_write <= pwrite;
    if (psel && s_tready) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] word(input int k);
    return {16'(k + 1), 16'(k)};
  endfunction

  function automatic logic [38:0] ent(input logic w, input int a, input logic [31:0] d);
    return {w, 6'(a), d};
  endfunction

  task automatic build_exp(input int nw, input bit full, input logic [31:0] st, input bit corr);
    exp_q.delete();
    exp_q.push_back(ent(1'b1, 32, 32'h1));
    for (int k = 0; k < nw; k++) exp_q.push_back(ent(1'b1, k * 4, word(k)));
    if (full) begin
      exp_q.push_back(ent(1'b1, 32, 32'h100));
      exp_q.push_back(ent(1'b0, 36, st));
`ifdef WIN_LOADER_READBACK_EN
      exp_q.push_back(ent(1'b1, 32, 32'h1));
      for (int k = 0; k < int'(N); k++)
        exp_q.push_back(ent(1'b0, k * 4, word(k) ^ ((corr && k == 2) ? 32'hFF : 32'h0)));
      exp_q.push_back(ent(1'b1, 32, 32'h100));
`else
      if (corr) exp_q.push_back(ent(1'b0, 0, 32'h0)); // never requested without readback
`endif
    end
  endtask

  task automatic cmp_log(input string t, input int base);
    int n;
    n = log_q.size() - base;
    check({t, "_nxfer"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_xfer%0d", t, i), 64'(log_q[base + i]), 64'(exp_q[i]));
  endtask

  // Start a sequence and feed words 0..last_idx; optionally reset or re-pulse start mid-way
  task automatic run_seq(input int gap, input int last_idx, input int rst_at, input int pulse_at,
                         output int lat);
    bit abort;
    abort = 1'b0;
    lat   = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin
        for (int k = 0; k <= last_idx && !abort; k++) begin
          int b;
          s_tvalid = 1'b0;
          for (int g = 0; g < gap; g++) @(negedge clk);
          s_tvalid = 1'b1;
          s_tdata  = word(k);
          s_tlast  = (k == last_idx);
          b = 0;
          while (!s_tready && !abort && b < 400) begin
            @(negedge clk);
            b++;
          end
          if (b >= 400) begin
            check("src_timeout", 64'(1), 64'(0));
            abort = 1'b1;
          end
          if (!abort) begin
            @(posedge clk);
            #1;
          end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      begin
        if (rst_at > 0) begin
          repeat (rst_at) @(negedge clk);
          check("pre_rst_access", 64'({psel, penable, paddr}), 64'({1'b1, 1'b1, 6'h0C}));
          abort = 1'b1;
          rst_n = 1'b0;
          @(negedge clk);
          check("post_rst", 64'({psel, penable, busy}), 64'(0));
          rst_n = 1'b1;
        end else begin
          int n;
          n = 0;
          while (n < 400 && !done) begin
            @(negedge clk);
            n++;
            start = (pulse_at > 0 && n == pulse_at);
          end
          start = 1'b0;
          lat = done ? n : -1;
        end
      end
    join
  endtask

  int base, d0, lat;

  task automatic finish_run(input string t, input int exp_lat, input logic [1:0] exp_err);
    check({t, "_lat"}, 64'(lat), 64'(exp_lat));
    check({t, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    check({t, "_busy_after"}, 64'(busy), 64'(0));
    check({t, "_err_held"}, 64'(err), 64'(exp_err));
    check({t, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    cmp_log(t, base);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o0;
    rst_n = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    status_val = 32'h0000_0100; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({psel, penable, pwrite, paddr, pwdata, s_tready, busy, done, err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back stream, good status
    base = log_q.size(); d0 = done_cnt;
    build_exp(8, 1'b1, 32'h100, 1'b0);
    run_seq(0, 7, 0, 0, lat);
    finish_run("t1", 31 + RBX, 2'd0);

    // 2: 5-cycle valid gaps before every word
    base = log_q.size(); d0 = done_cnt; o0 = overlap;
    run_seq(5, 7, 0, 0, lat);
    finish_run("t2", 47 + RBX, 2'd0);
    check("t2_psel_in_fetch", 64'(overlap - o0), 64'(0));

    // 3: early tlast on word 4
    base = log_q.size(); d0 = done_cnt;
    build_exp(4, 1'b0, 32'h0, 1'b0);
    run_seq(0, 4, 0, 0, lat);
    finish_run("t3", 16, 2'd1);

    // 4: status not WAIT
    status_val = 32'h0;
    base = log_q.size(); d0 = done_cnt;
    build_exp(8, 1'b1, 32'h0, 1'b0);
    run_seq(0, 7, 0, 0, lat);
    finish_run("t4", 31 + RBX, 2'd2);
    status_val = 32'h0000_0100;

    // 5: reset during ACCESS of word 3, then full restart
    run_seq(0, 7, 14, 0, lat);
    repeat (2) @(negedge clk);
    base = log_q.size(); d0 = done_cnt;
    build_exp(8, 1'b1, 32'h100, 1'b0);
    run_seq(0, 7, 0, 0, lat);
    finish_run("t5", 31 + RBX, 2'd0);

    // 6: start pulsed while busy; readback of word 2 corrupted
    corrupt = 1'b1;
    base = log_q.size(); d0 = done_cnt;
`ifdef WIN_LOADER_READBACK_EN
    build_exp(8, 1'b1, 32'h100, 1'b1);
    run_seq(0, 7, 0, 10, lat);
    finish_run("t6", 31 + RBX, 2'd3);
`else
    build_exp(8, 1'b1, 32'h100, 1'b0);
    run_seq(0, 7, 0, 10, lat);
    finish_run("t6", 31, 2'd0);
`endif
    repeat (3) @(negedge clk);
    check("t6_no_restart", 64'(busy), 64'(0));
    check("apb_protocol", 64'(viol), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
